// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, ALU opcode constants and opcode-class helpers for the
// integer execution unit and the reservation station that feeds it.
package alu_pkg;
   localparam int XLEN           = 32;
   localparam int ALU_OP_WIDTH   = 4;
   localparam int ROB_SIZE_WIDTH = 3;
   localparam int SHAMT_WIDTH    = 5;

   localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'd0;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 4'd1;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'd2;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'd3;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'd4;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SHL  = 4'd5;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SHR  = 4'd6;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SHRA = 4'd7;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ   = 4'd8;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_NEQ  = 4'd9;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_LT   = 4'd10;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU  = 4'd11;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_GE   = 4'd12;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU  = 4'd13;

   function automatic logic is_cmp(input logic [ALU_OP_WIDTH-1:0] op);
      return op >= ALU_EQ && op <= ALU_GEU;
   endfunction
endpackage

// File: rtl/alu_compare.sv
// alu_compare: the six compare/branch-condition ops, producing 1 or 0 on the
// full datapath width; non-compare opcodes yield 0.
module alu_compare
   import alu_pkg::*;
(
   input  logic [ALU_OP_WIDTH-1:0] op,
   input  logic [XLEN-1:0]         a,
   input  logic [XLEN-1:0]         b,
   output logic [XLEN-1:0]         res
);
   logic eq, lt, ltu, hit;
   assign eq  = a == b;
   assign lt  = $signed(a) < $signed(b);
   assign ltu = a < b;
   assign hit = op == ALU_EQ  ? eq   :
                op == ALU_NEQ ? !eq  :
                op == ALU_LT  ? lt   :
                op == ALU_LTU ? ltu  :
                op == ALU_GE  ? !lt  :
                op == ALU_GEU ? !ltu : 1'b0;
   assign res = {{(XLEN-1){1'b0}}, hit};
endmodule

// File: rtl/alu.sv
// alu: single-issue RV32I integer unit; accepts every issue from the reservation
// station and broadcasts the registered result one cycle later.
module alu
   import alu_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      flush,
   input  logic                      rs_ready,
   input  logic [ALU_OP_WIDTH-1:0]   rs_op,
   input  logic [XLEN-1:0]           rs_val1,
   input  logic [XLEN-1:0]           rs_val2,
   input  logic [ROB_SIZE_WIDTH-1:0] rs_id,
   output logic                      alu_ready,
   output logic [XLEN-1:0]           alu_res,
   output logic [ROB_SIZE_WIDTH-1:0] alu_id
);
   logic [SHAMT_WIDTH-1:0] shamt;
   logic [XLEN-1:0]        cmp_res, next_res;

   assign shamt = rs_val2[SHAMT_WIDTH-1:0];

   alu_compare u_cmp (
      .op  (rs_op),
      .a   (rs_val1),
      .b   (rs_val2),
      .res (cmp_res)
   );

   // Undefined opcodes fall through to 0 but still pulse alu_ready so the ROB entry retires.
   always_comb begin
      next_res = '0;
      case (rs_op)
         ALU_ADD:  next_res = rs_val1 + rs_val2;
         ALU_SUB:  next_res = rs_val1 - rs_val2;
         ALU_AND:  next_res = rs_val1 & rs_val2;
         ALU_OR:   next_res = rs_val1 | rs_val2;
         ALU_XOR:  next_res = rs_val1 ^ rs_val2;
         ALU_SHL:  next_res = rs_val1 << shamt;
         ALU_SHR:  next_res = rs_val1 >> shamt;
         ALU_SHRA: next_res = $signed(rs_val1) >>> shamt;
         default:  next_res = is_cmp(rs_op) ? cmp_res : '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rdy) begin
         if (rst) begin
            alu_ready <= 1'b0;
            alu_res   <= '0;
            alu_id    <= '0;
         end else if (flush) begin
            alu_ready <= 1'b0;
         end else begin
            alu_ready <= rs_ready;
            if (rs_ready) begin
               alu_res <= next_res;
               alu_id  <= rs_id;
            end
         end
      end
   end
endmodule

// File: tb/tb_alu.sv
// tb_alu: table vectors, hand sequences for flush/rdy/reset corners, and random
// traffic checked against a plain-arithmetic reference model.
module tb_alu;
   logic        clk = 0, rst, rdy, flush, rs_ready;
   logic [3:0]  rs_op;
   logic [31:0] rs_val1, rs_val2;
   logic [2:0]  rs_id;
   logic        alu_ready;
   logic [31:0] alu_res;
   logic [2:0]  alu_id;

   int n_cmp = 0, n_bad = 0;
   logic        e_ready = 0;
   logic [31:0] e_res = 0;
   logic [2:0]  e_id = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [2:0]  id;
      logic [31:0] res;
   } vec_t;
   vec_t v[10];

   alu dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .rs_ready(rs_ready),
      .rs_op(rs_op), .rs_val1(rs_val1), .rs_val2(rs_val2), .rs_id(rs_id),
      .alu_ready(alu_ready), .alu_res(alu_res), .alu_id(alu_id)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint unsigned ua = 64'(a);
      longint unsigned ub = 64'(b);
      int              sh = int'(b[4:0]);
      case (op)
         4'd0:    return 32'(ua + ub);
         4'd1:    return 32'(ua - ub);
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return 32'(ua * (64'd1 << sh));
         4'd6:    return 32'(ua / (64'd1 << sh));
         4'd7:    return 32'(sa >>> sh);
         4'd8:    return (ua == ub) ? 1 : 0;
         4'd9:    return (ua != ub) ? 1 : 0;
         4'd10:   return (sa < sb) ? 1 : 0;
         4'd11:   return (ua < ub) ? 1 : 0;
         4'd12:   return (sa >= sb) ? 1 : 0;
         4'd13:   return (ua >= ub) ? 1 : 0;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [2:0] id);
      rs_ready = 1; rs_op = op; rs_val1 = a; rs_val2 = b; rs_id = id;
   endtask

   task automatic idle();
      rs_ready = 0;
   endtask

   // Advance one clock, updating the model from the inputs presented this cycle, and compare.
   task automatic cyc(input string name);
      if (rdy) begin
         if (rst) begin
            e_ready = 0; e_res = 0; e_id = 0;
         end else if (flush) begin
            e_ready = 0;
         end else begin
            e_ready = rs_ready;
            if (rs_ready) begin
               e_res = ref_alu(rs_op, rs_val1, rs_val2);
               e_id = rs_id;
            end
         end
      end
      @(posedge clk); #1;
      chk({name, ".ready"}, 32'(alu_ready), 32'(e_ready));
      chk({name, ".res"}, alu_res, e_res);
      chk({name, ".id"}, 32'(alu_id), 32'(e_id));
   endtask

   initial begin
      v[0] = '{4'd10, 32'hFFFFFFFF, 32'd1, 3'd0, 32'd1};
      v[1] = '{4'd13, 32'hFFFFFFFF, 32'd1, 3'd1, 32'd1};
      v[2] = '{4'd12, 32'hFFFFFFFF, 32'd1, 3'd2, 32'd0};
      v[3] = '{4'd8,  32'd7,        32'd7, 3'd3, 32'd1};
      v[4] = '{4'd9,  32'd7,        32'd7, 3'd4, 32'd0};
      v[5] = '{4'd15, 32'h12345678, 32'd9, 3'd7, 32'd0};
      v[6] = '{4'd5,  32'h00000001, 32'hFFFFFFE3, 3'd5, 32'h00000008};
      v[7] = '{4'd6,  32'h80000000, 32'd31, 3'd6, 32'h00000001};
      v[8] = '{4'd11, 32'd5,        32'd5, 3'd2, 32'd0};
      v[9] = '{4'd4,  32'hF0F0F0F0, 32'h0FF00FF0, 3'd1, 32'hFF00FF00};

      rst = 1; rdy = 1; flush = 0; rs_ready = 0; rs_op = 0; rs_val1 = 0; rs_val2 = 0; rs_id = 0;
      cyc("reset");
      chk("reset.ready_const", 32'(alu_ready), 0);
      rst = 0;

      issue(4'd0, 32'd5, 32'd7, 3'd3); cyc("add");
      chk("add.res_const", alu_res, 32'd12);
      chk("add.id_const", 32'(alu_id), 32'd3);
      idle(); cyc("add.idle");
      chk("add.hold", alu_res, 32'd12);

      issue(4'd1, 32'd0, 32'd1, 3'd1); cyc("b2b.sub");
      chk("b2b.sub_const", alu_res, 32'hFFFFFFFF);
      issue(4'd7, 32'h80000000, 32'h24, 3'd2); cyc("b2b.shra");
      chk("b2b.shra_const", alu_res, 32'hF8000000);
      issue(4'd11, 32'd1, 32'hFFFFFFFF, 3'd4); cyc("b2b.ltu");
      chk("b2b.ltu_const", alu_res, 32'd1);
      chk("b2b.ltu_id", 32'(alu_id), 32'd4);
      idle(); cyc("b2b.end");

      for (int i = 0; i < 10; i++) begin
         issue(v[i].op, v[i].a, v[i].b, v[i].id); cyc($sformatf("vec%0d", i));
         chk($sformatf("vec%0d.table_res", i), alu_res, v[i].res);
         chk($sformatf("vec%0d.table_ready", i), 32'(alu_ready), 32'd1);
      end
      idle(); cyc("vec.end");

      issue(4'd0, 32'd1, 32'd1, 3'd5); flush = 1; cyc("flush");
      chk("flush.ready_const", 32'(alu_ready), 0);
      chk("flush.id_kept", 32'(alu_id), 32'd1);
      flush = 0; issue(4'd0, 32'd2, 32'd3, 3'd6); cyc("post_flush");
      chk("post_flush.id_const", 32'(alu_id), 32'd6);
      idle(); cyc("post_flush.idle");

      rdy = 0; issue(4'd0, 32'd9, 32'd9, 3'd2); cyc("rdy0.issue");
      chk("rdy0.no_pulse", 32'(alu_ready), 0);
      rdy = 1; issue(4'd2, 32'hFF, 32'h0F, 3'd3); cyc("rdy.pulse");
      rdy = 0; idle(); cyc("rdy0.hold1");
      chk("rdy0.pulse_held", 32'(alu_ready), 1);
      cyc("rdy0.hold2");
      rst = 1; cyc("rdy0.rst_ignored");
      chk("rdy0.rst_res", alu_res, 32'h0F);
      rst = 0; rdy = 1; cyc("rdy.back");
      chk("rdy.back_ready", 32'(alu_ready), 0);

      issue(4'd0, 32'd4, 32'd4, 3'd7); cyc("pre_rst");
      issue(4'd0, 32'd8, 32'd8, 3'd1); rst = 1; cyc("mid_rst");
      chk("mid_rst.res_const", alu_res, 0);
      rst = 0;

      for (int i = 0; i < 400; i++) begin
         rdy = ($urandom % 8) != 0;
         rst = ($urandom % 64) == 0;
         flush = ($urandom % 10) == 0;
         rs_ready = ($urandom % 4) != 0;
         rs_op = 4'($urandom % 16);
         case ($urandom % 4)
            0: rs_val1 = 32'h80000000 >> ($urandom % 2);
            1: rs_val1 = 32'($urandom % 4) - 32'd2;
            default: rs_val1 = $urandom;
         endcase
         rs_val2 = ($urandom % 3 == 0) ? rs_val1 : $urandom;
         rs_id = 3'($urandom);
         cyc("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
